// File: rtl/fwrisc_decode.sv
// fwrisc decode stage: latches one fetched RV32I/M instruction, reads its sources
// from the synchronous register file and presents a registered operand bundle.
module fwrisc_decode #(
  parameter int unsigned ENABLE_MUL_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [5:0]  rs1_raddr,
  output logic [5:0]  rs2_raddr,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  output logic        decode_valid,
  input  logic        exec_ready,
  output logic [1:0]  op_type,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_c,
  output logic [5:0]  op,
  output logic [5:0]  rd,
  output logic        illegal,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never drops and the payload never changes until that edge.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] OPT_ALU  = 2'd0;
  localparam logic [1:0] OPT_MDS  = 2'd1;
  localparam logic [1:0] OPT_LDST = 2'd2;
  localparam logic [1:0] OPT_BR   = 2'd3;

  localparam bit MD_EN = (ENABLE_MUL_DIV != 0);

  state_e      state_q, state_d;
  logic [31:0] instr_q, pc_q;
  logic [1:0]  op_type_q;
  logic [31:0] op_a_q, op_b_q, op_c_q;
  logic [5:0]  op_q, rd_q;
  logic        illegal_q;

  logic [31:0] src_instr;
  logic [2:0]  f3;
  logic        is_mext, is_shift;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, jalr_sum;
  logic [1:0]  dec_type;
  logic [31:0] dec_a, dec_b, dec_c;
  logic [5:0]  dec_op, dec_rd;
  logic        dec_ill;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fetch_valid) state_d = ST_READ;
      ST_READ:  state_d = ST_VALID;
      ST_VALID: if (exec_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // In IDLE the register file must be addressed in the same cycle as the accept.
  assign src_instr = (state_q == ST_IDLE) ? instr : instr_q;
  assign rs1_raddr = {1'b0, src_instr[19:15]};
  assign rs2_raddr = {1'b0, src_instr[24:20]};

  assign f3       = instr_q[14:12];
  assign is_mext  = (instr_q[31:25] == 7'b0000001);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm_i    = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                     instr_q[11:8], 1'b0};
  assign imm_u    = {instr_q[31:12], 12'b0};
  assign imm_j    = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                     instr_q[30:21], 1'b0};
  assign jalr_sum = rs1_rdata + imm_i;

  always_comb begin
    dec_type = OPT_ALU;
    dec_a    = 32'd0;
    dec_b    = 32'd0;
    dec_c    = 32'd0;
    dec_op   = 6'd0;
    dec_rd   = {1'b0, instr_q[11:7]};
    dec_ill  = 1'b0;
    case (instr_q[6:0])
      OPC_OP: begin
        if (is_mext && !MD_EN) begin
          dec_ill = 1'b1;
          dec_rd  = 6'd0;
        end else begin
          dec_a    = rs1_rdata;
          dec_b    = rs2_rdata;
          dec_op   = {1'b0, instr_q[25], instr_q[30], f3};
          dec_type = (is_mext || is_shift) ? OPT_MDS : OPT_ALU;
        end
      end
      OPC_OPIMM: begin
        dec_a  = rs1_rdata;
        dec_op = {3'b000, f3};
        if (is_shift) begin
          dec_b     = {27'd0, instr_q[24:20]};
          dec_type  = OPT_MDS;
          dec_op[3] = instr_q[30];
        end else begin
          dec_b = imm_i;
        end
      end
      OPC_LUI: dec_b = imm_u;
      OPC_AUIPC: begin
        dec_a = pc_q;
        dec_b = imm_u;
      end
      OPC_LOAD: begin
        dec_type = OPT_LDST;
        dec_a    = rs1_rdata;
        dec_b    = imm_i;
        dec_op   = {3'b000, f3};
      end
      OPC_STORE: begin
        dec_type = OPT_LDST;
        dec_a    = rs1_rdata;
        dec_b    = imm_s;
        dec_c    = rs2_rdata;
        dec_op   = {3'b001, f3};
        dec_rd   = 6'd0;
      end
      OPC_BRANCH: begin
        dec_type = OPT_BR;
        dec_a    = rs1_rdata;
        dec_b    = rs2_rdata;
        dec_c    = pc_q + imm_b;
        dec_op   = {3'b000, f3};
        dec_rd   = 6'd0;
      end
      OPC_JAL: begin
        dec_type = OPT_BR;
        dec_a    = pc_q;
        dec_b    = 32'd4;
        dec_c    = pc_q + imm_j;
        dec_op   = 6'b001000;
      end
      OPC_JALR: begin
        dec_type = OPT_BR;
        dec_a    = pc_q;
        dec_b    = 32'd4;
        dec_c    = {jalr_sum[31:1], 1'b0};
        dec_op   = 6'b011000;
      end
      default: begin
        dec_ill = 1'b1;
        dec_rd  = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= 32'd0;
      pc_q      <= 32'd0;
      op_type_q <= 2'd0;
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      op_c_q    <= 32'd0;
      op_q      <= 6'd0;
      rd_q      <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && fetch_valid) begin
        instr_q <= instr;
        pc_q    <= pc;
      end
      if (state_q == ST_READ) begin
        op_type_q <= dec_type;
        op_a_q    <= dec_a;
        op_b_q    <= dec_b;
        op_c_q    <= dec_c;
        op_q      <= dec_op;
        rd_q      <= dec_rd;
        illegal_q <= dec_ill;
      end
    end
  end

  assign fetch_ready  = (state_q == ST_IDLE) && !reset;
  assign decode_valid = (state_q == ST_VALID);
  assign op_type      = op_type_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_c         = op_c_q;
  assign op           = op_q;
  assign rd           = rd_q;
  assign illegal      = illegal_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/fwrisc_decode.md
# fwrisc_decode

Instruction decode stage of the fwrisc core, directly upstream of the execute stage. Accepts one fetched RV32I/M instruction and its PC, reads up to two source registers from the synchronous-read register file, and presents a registered operand bundle (`op_type`, `op_a`, `op_b`, `op_c`, `op`, `rd`) to execute under a valid/ready handshake. One instruction is in flight at a time.

## Interface
- `ENABLE_MUL_DIV`, default 1: 1 means M-extension ops decode to `op_type`=MDS; 0 means they flag `illegal`.

- `clock` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `fetch_valid` in 1: `instr`/`pc` valid
- `fetch_ready` out 1: decode can accept an instruction
- `instr` in 32: instruction word
- `pc` in 32: address of `instr`
- `rs1_raddr` out 6: register-file read address 1, `{1'b0, instr[19:15]}`
- `rs2_raddr` out 6: register-file read address 2, `{1'b0, instr[24:20]}`
- `rs1_rdata` in 32: read data 1, valid the cycle after the address
- `rs2_rdata` in 32: read data 2, valid the cycle after the address
- `decode_valid` out 1: operand bundle valid
- `exec_ready` in 1: execute accepts the bundle
- `op_type` out 2: 0=ALU, 1=MDS (mul/div/shift), 2=LDST, 3=BRANCH/JUMP
- `op_a` out 32: first operand
- `op_b` out 32: second operand
- `op_c` out 32: store data or branch/jump target
- `op` out 6: `[2:0]`=funct3, `[3]`=sub/sra/store/jump, `[4]`=M-ext/JALR, `[5]`=0
- `rd` out 6: destination, `{1'b0, instr[11:7]}`; 0 when there is no writeback
- `illegal` out 1: unsupported opcode

## Operation
- The FSM has three states, and reset enters IDLE.
  - IDLE: `fetch_ready`=1. Accept occurs when `fetch_valid` is high, giving IDLE→READ. `instr` and `pc` are latched at the accept edge.
  - READ: `rs*_rdata` is valid. Decoded outputs are registered at the end of this cycle, giving READ→VALID.
  - VALID: `decode_valid`=1 and all outputs are held stable. When `exec_ready` is high, the transfer occurs and the state returns to IDLE.
- `rs*_raddr` are combinational from `instr` in IDLE. In other states they come from the latched instruction.
- Immediates are sign-extended from bit 31 unless noted otherwise.
- Per-opcode decode (`op_c`=0 unless stated):
  - OP (0110011): `op_a`=rs1, `op_b`=rs2, `op[3]`=instr[30], `op[4]`=instr[25]. `op_type` is MDS when funct7=0000001 or funct3∈{001,101}, otherwise ALU.
  - OP-IMM (0010011): `op_a`=rs1, `op_b`=I-imm. Shifts (funct3 001/101) use `op_b`={27'b0,shamt}, `op_type`=MDS and `op[3]`=instr[30]. All other OP-IMM ops use `op[3]`=0.
  - LUI: `op_a`=0, `op_b`=U-imm, ALU ADD.
  - AUIPC: `op_a`=pc, `op_b`=U-imm, ALU ADD.
  - LOAD: LDST, `op_a`=rs1, `op_b`=I-imm, `op[3]`=0.
  - STORE: LDST, `op_a`=rs1, `op_b`=S-imm, `op_c`=rs2, `op[3]`=1, `rd`=0.
  - BRANCH: `op_a`=rs1, `op_b`=rs2, `op_c`=pc+B-imm (mod 2^32), `rd`=0.
  - JAL: `op_a`=pc, `op_b`=4, `op_c`=pc+J-imm, `op[3]`=1.
  - JALR: `op_a`=pc, `op_b`=4, `op_c`=(rs1+I-imm)&~1, `op[3]`=1, `op[4]`=1.
  - Any other opcode, or M-ext with `ENABLE_MUL_DIV`=0: `illegal`=1, `op_type`=ALU, `rd`=0, `op_a`=`op_b`=0.
- All adds are 32-bit and wrap with no carry-out.

## Timing
- Reset values: `fetch_ready`=0 during reset, then 1 in the first IDLE cycle. All other registered outputs, including `decode_valid` and `illegal`, reset to 0.
- Latency: accept in cycle N gives `decode_valid`=1 in cycle N+2. Minimum issue interval is 3 cycles, with back-to-back instructions spaced by the IDLE cycle.
- `fetch_ready`=0 in READ and VALID. `fetch_valid` is ignored there.
- `decode_valid` stays high and outputs stay stable until `exec_ready` is sampled high. `exec_ready` high while not VALID has no effect.
- Reset asserted in any state returns to IDLE with outputs cleared. The in-flight instruction is discarded.
- The register file must return 0 for address 0. Decode does not special-case x0.

## Test plan
- ADD x3,x1,x2 (0x002081B3), regfile x1=5 and x2=7, accepted cycle 0, `exec_ready`=1 → cycle 2: `decode_valid`=1, `op_type`=0, `op_a`=5, `op_b`=7, `op`=0, `rd`=3; `fetch_ready`=1 in cycle 3.
- ADDI x1,x0,-1 (0xFFF00093) → `op_b`=0xFFFFFFFF, `op_type`=0. SRAI x1,x1,3 (0x4030D093) → `op_type`=1, `op_b`=3, `op[3]`=1.
- BEQ x1,x2,-8 at pc=0x100 → `op_type`=3, `op_c`=0x000000F8, `rd`=0. JALR x1,4(x5) with x5=0x203 → `op_a`=pc, `op_b`=4, `op_c`=0x206.
- SW x2,8(x1) (0x0020A423), x1=0x1000, x2=0xAA → `op_type`=2, `op_a`=0x1000, `op_b`=8, `op_c`=0xAA, `op[3]`=1, `rd`=0.
- `exec_ready` held 0 for 5 cycles → `decode_valid` and all outputs stable, `fetch_ready`=0. Then `exec_ready`=1 → IDLE the next cycle.
- MUL (0x022081B3) with `ENABLE_MUL_DIV`=0 → `illegal`=1, `rd`=0. Opcode 0x7F → `illegal`=1. Reset in READ → `decode_valid` never rises and `fetch_ready`=1 after reset release.
